// File: rtl/div_arbiter_if.sv
// div_arbiter_if
//   Valid/ready link between div_arbiter and one shared iterative
//   floating-point divider.
//   master : arbiter side  (drives operands, valid and cancel)
//   slave  : divider side  (drives ready, result valid, quotient, flags)
//   div_in_valid/div_in_ready  operand handshake
//   div_a, div_b, div_round_mode  operands and rounding mode
//   div_cancel     one-cycle abort of the operation in flight
//   div_out_valid  one-cycle result strobe with div_out/div_exceptions
interface div_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             div_in_valid;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic [2:0]       div_round_mode;
  logic             div_cancel;
  logic             div_in_ready;
  logic             div_out_valid;
  logic [WIDTH-1:0] div_out;
  logic [4:0]       div_exceptions;

  modport master (
    output div_in_valid, div_a, div_b, div_round_mode, div_cancel,
    input  div_in_ready, div_out_valid, div_out, div_exceptions
  );

  modport slave (
    input  div_in_valid, div_a, div_b, div_round_mode, div_cancel,
    output div_in_ready, div_out_valid, div_out, div_exceptions
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter
//   Round-robin arbiter/sequencer sharing one iterative divider among
//   N_REQ requesters. One operation is outstanding at a time; the result is
//   returned tagged with the requester ID. A flush input and a watchdog
//   cancel a hung operation.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester request and one-hot accept strobe
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   round_mode          rounding mode, captured with the grant
//   flush               abort the in-flight operation / pending response
//   div_if              divider link (master side)
//   resp_*              response channel with valid/ready handshake
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2:0]             round_mode,
  input  logic                   flush,
  div_arbiter_if.master          div_if,
  output logic                   resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [4:0]             resp_exc,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_timeout,
  input  logic                   resp_ready
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        rm_q, rm_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [WIDTH-1:0]  resp_data_q, resp_data_d;
  logic [4:0]        resp_exc_q, resp_exc_d;
  logic              resp_timeout_q, resp_timeout_d;
  logic              resp_valid_q, resp_valid_d;
  logic              div_in_valid_q, div_in_valid_d;
  logic              div_cancel_q, div_cancel_d;

  logic [WIDTH-1:0]  req_a_arr [N_REQ];
  logic [WIDTH-1:0]  req_b_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign req_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // (ptr + off) mod N_REQ for off in 1..N_REQ; the sum stays below 2*N_REQ,
  // so a single conditional subtract is enough.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] ptr,
                                               input int unsigned   off);
    int unsigned s;
    s = 32'(ptr) + off;
    if (s >= 32'(N_REQ)) s = s - 32'(N_REQ);
    return s[ID_W-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest valid requester after
  // rr_ptr is the one that sticks.
  logic            grant_found;
  logic [ID_W-1:0] grant_id;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[wrap_idx(rr_ptr_q, 32'(k))]) begin
        grant_found = 1'b1;
        grant_id    = wrap_idx(rr_ptr_q, 32'(k));
      end
    end
  end

  // The accept strobe is combinational; it is gated by rst so every output
  // reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && !rst) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    a_d            = a_q;
    b_d            = b_q;
    rm_d           = rm_q;
    wd_cnt_d       = wd_cnt_q;
    resp_data_d    = resp_data_q;
    resp_exc_d     = resp_exc_q;
    resp_timeout_d = resp_timeout_q;
    resp_valid_d   = resp_valid_q;
    div_in_valid_d = div_in_valid_q;
    div_cancel_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d        = S_ISSUE;
          rr_ptr_d       = grant_id;
          id_d           = grant_id;
          a_d            = req_a_arr[grant_id];
          b_d            = req_b_arr[grant_id];
          rm_d           = round_mode;
          div_in_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        // flush wins even if the divider accepts in the same cycle; the
        // cancel pulse then aborts whatever it took.
        if (flush) begin
          state_d        = S_IDLE;
          div_in_valid_d = 1'b0;
          div_cancel_d   = 1'b1;
        end else if (div_if.div_in_ready) begin
          state_d        = S_WAIT;
          div_in_valid_d = 1'b0;
          wd_cnt_d       = '0;
        end
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (flush) begin
          state_d      = S_IDLE;
          div_cancel_d = 1'b1;
        end else if (div_if.div_out_valid) begin
          state_d        = S_RESP;
          resp_data_d    = div_if.div_out;
          resp_exc_d     = div_if.div_exceptions;
          resp_timeout_d = 1'b0;
          resp_valid_d   = 1'b1;
        end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          state_d        = S_RESP;
          div_cancel_d   = 1'b1;
          resp_data_d    = '0;
          resp_exc_d     = '0;
          resp_timeout_d = 1'b1;
          resp_valid_d   = 1'b1;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= ID_W'(N_REQ - 1);
      id_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      rm_q           <= '0;
      wd_cnt_q       <= '0;
      resp_data_q    <= '0;
      resp_exc_q     <= '0;
      resp_timeout_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      div_in_valid_q <= 1'b0;
      div_cancel_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      a_q            <= a_d;
      b_q            <= b_d;
      rm_q           <= rm_d;
      wd_cnt_q       <= wd_cnt_d;
      resp_data_q    <= resp_data_d;
      resp_exc_q     <= resp_exc_d;
      resp_timeout_q <= resp_timeout_d;
      resp_valid_q   <= resp_valid_d;
      div_in_valid_q <= div_in_valid_d;
      div_cancel_q   <= div_cancel_d;
    end
  end

  assign div_if.div_in_valid   = div_in_valid_q;
  assign div_if.div_a          = a_q;
  assign div_if.div_b          = b_q;
  assign div_if.div_round_mode = rm_q;
  assign div_if.div_cancel     = div_cancel_q;

  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_exc     = resp_exc_q;
  assign resp_id      = id_q;
  assign resp_timeout = resp_timeout_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
//   Self-checking bench for div_arbiter: directed scenarios followed by a
//   randomized run, checked against a transaction-level reference model and
//   a behavioural divider stub.
module tb_div_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [2:0]     round_mode;
  logic           flush;
  logic           resp_valid;
  logic [W-1:0]   resp_data;
  logic [4:0]     resp_exc;
  logic [IDW-1:0] resp_id;
  logic           resp_timeout;
  logic           resp_ready;

  div_arbiter_if #(.WIDTH(W)) dif ();

  div_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .round_mode(round_mode), .flush(flush), .div_if(dif),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_exc(resp_exc),
    .resp_id(resp_id), .resp_timeout(resp_timeout), .resp_ready(resp_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // Reference model: one outstanding operation at a time.
  bit           op_live, op_issued, have_resp, exp_cancel, exp_to;
  int           op_id, last_grant, wait_cycles;
  logic [W-1:0] op_a, op_b, exp_data;
  logic [2:0]   op_rm;
  logic [4:0]   exp_exc;

  // Divider stub state and knobs.
  bit           stub_busy, stub_hang, hang_all, rand_hang, spur_en, drop_on_grant;
  int           stub_cnt, stub_lat, ready_pct;
  logic [W-1:0] stub_a, stub_b;

  // Observation logs.
  int           cyc, n_resp, n_cancel, n_rv, hs_cyc, outv_cyc, resp_start_cyc;
  bit           prev_resp_valid;
  logic [N-1:0] last_req_ready;
  int           grant_log[$];
  logic [W-1:0] log_data[$];
  logic [4:0]   log_exc[$];
  int           log_id[$];
  bit           log_to[$];

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] stub_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'hC1400000 && b == 32'h40800000) return 32'hC0400000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic logic [4:0] stub_e(input logic [W-1:0] a, input logic [W-1:0] b);
    return a[4:0] ^ b[9:5];
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; round_mode = '0; flush = 1'b0; resp_ready = 1'b1;
    dif.div_in_ready = 1'b0; dif.div_out_valid = 1'b0; dif.div_out = '0; dif.div_exceptions = '0;
    op_live = 0; op_issued = 0; have_resp = 0; exp_cancel = 0; last_grant = N - 1; wait_cycles = 0;
    stub_busy = 0; stub_cnt = 0; stub_hang = 0; prev_resp_valid = 0;
    hang_all = 0; rand_hang = 0; spur_en = 0; drop_on_grant = 1; ready_pct = 100; stub_lat = 3;
    n_resp = 0; grant_log.delete(); log_data.delete(); log_exc.delete(); log_id.delete(); log_to.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: inputs set by the caller, stub drives the divider side,
  // outputs are checked mid-cycle, then the model advances across the edge.
  task automatic cycle();
    logic [N-1:0] exp_rr;
    int g;
    bit waiting;
    dif.div_in_ready = !stub_busy && ($urandom_range(99) < ready_pct);
    if (stub_busy) begin
      dif.div_out_valid  = (stub_cnt == 0) && !stub_hang;
      dif.div_out        = stub_q(stub_a, stub_b);
      dif.div_exceptions = stub_e(stub_a, stub_b);
    end else begin
      dif.div_out_valid  = spur_en && ($urandom_range(9) == 0);
      dif.div_out        = $urandom;
      dif.div_exceptions = 5'($urandom);
    end
    #1;
    exp_rr = '0;
    g = -1;
    if (!op_live) begin
      g = pick(req_valid, last_grant);
      if (g >= 0) exp_rr[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_rr);
    check("div_in_valid", dif.div_in_valid, op_live && !op_issued);
    if (op_live && !op_issued) begin
      check("div_a", dif.div_a, op_a);
      check("div_b", dif.div_b, op_b);
      check("div_round_mode", dif.div_round_mode, op_rm);
    end
    check("div_cancel", dif.div_cancel, exp_cancel);
    check("resp_valid", resp_valid, have_resp);
    if (have_resp) begin
      check("resp_data", resp_data, exp_data);
      check("resp_exc", resp_exc, exp_exc);
      check("resp_id", resp_id, op_id);
      check("resp_timeout", resp_timeout, exp_to);
    end
    last_req_ready = req_ready;
    if (dif.div_cancel) n_cancel++;
    if (resp_valid) n_rv++;
    if (resp_valid && !prev_resp_valid) resp_start_cyc = cyc;
    prev_resp_valid = resp_valid;
    if (dif.div_in_valid && dif.div_in_ready) hs_cyc = cyc;
    waiting = op_live && op_issued && !have_resp;
    if (waiting && dif.div_out_valid) outv_cyc = cyc;

    exp_cancel = 0;
    if (flush && op_live) begin
      if (!have_resp) exp_cancel = 1;
      $display("[TB] flush id=%0d dropped", op_id);
      op_live = 0; op_issued = 0; have_resp = 0;
    end else if (op_live) begin
      if (have_resp) begin
        if (resp_ready) begin
          $display("[TB] resp id=%0d data=%08h exc=%02h timeout=%0d", op_id, exp_data, exp_exc, exp_to);
          log_data.push_back(exp_data); log_exc.push_back(exp_exc);
          log_id.push_back(op_id); log_to.push_back(exp_to);
          n_resp++;
          op_live = 0; have_resp = 0;
        end
      end else if (!op_issued) begin
        if (dif.div_in_ready) begin op_issued = 1; wait_cycles = 0; end
      end else begin
        wait_cycles++;
        if (dif.div_out_valid) begin
          have_resp = 1; exp_data = dif.div_out; exp_exc = dif.div_exceptions; exp_to = 0;
        end else if (wait_cycles == TO) begin
          have_resp = 1; exp_data = '0; exp_exc = '0; exp_to = 1; exp_cancel = 1;
        end
      end
    end else if (g >= 0) begin
      op_live = 1; op_issued = 0; op_id = g; last_grant = g;
      op_a = req_a[g*W +: W]; op_b = req_b[g*W +: W]; op_rm = round_mode;
      grant_log.push_back(g);
    end

    if (dif.div_cancel) stub_busy = 0;
    else if (stub_busy) begin
      if (dif.div_out_valid) stub_busy = 0;
      else if (stub_cnt > 0) stub_cnt--;
    end
    if (dif.div_in_valid && dif.div_in_ready) begin
      stub_busy = 1; stub_cnt = stub_lat; stub_a = dif.div_a; stub_b = dif.div_b;
      stub_hang = hang_all || (rand_hang && $urandom_range(15) == 0);
    end
    cyc++;
    @(negedge clk);
    if (drop_on_grant && g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic run_until_resp(input int target, input int budget);
    int k;
    k = 0;
    while (n_resp < target && k < budget) begin cycle(); k++; end
    check("resp_arrived", n_resp >= target, 1);
  endtask

  initial begin
    int k, c0, rv0, r0;
    cyc = 0; n_cancel = 0; n_rv = 0; hs_cyc = 0; outv_cyc = 0; resp_start_cyc = 0;

    // Reset state
    do_reset();
    check("rst_req_ready", req_ready, 0);
    check("rst_div_in_valid", dif.div_in_valid, 0);
    check("rst_div_cancel", dif.div_cancel, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);

    // Single request
    set_req(0, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0001;
    run_until_resp(1, 40);
    check("t1_data", log_data[0], 32'h40400000);
    check("t1_exc", log_exc[0], 0);
    check("t1_id", log_id[0], 0);
    check("t1_timeout", log_to[0], 0);
    check("t1_resp_latency", resp_start_cyc - outv_cyc, 1);

    // Simultaneous requests from 0 and 2
    do_reset();
    set_req(2, 32'hC1400000, 32'h40800000);
    set_req(0, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0101;
    run_until_resp(2, 80);
    check("t2_first_data", log_data[0], 32'h40400000);
    check("t2_first_id", log_id[0], 0);
    check("t2_second_data", log_data[1], 32'hC0400000);
    check("t2_second_id", log_id[1], 2);

    // Fairness: all requesters held valid
    do_reset();
    drop_on_grant = 0;
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
    req_valid = 4'b1111;
    run_until_resp(8, 200);
    req_valid = '0;
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) check("t3_grant_order", grant_log[i], i % 4);

    // Backpressure on the response
    do_reset();
    set_req(0, $urandom, $urandom);
    req_valid = 4'b0001;
    resp_ready = 1'b0;
    k = 0;
    while (!have_resp && k < 40) begin cycle(); k++; end
    check("t4_reached_resp", have_resp, 1);
    req_valid = 4'b1110;
    for (int i = 0; i < 5; i++) cycle();
    resp_ready = 1'b1;
    cycle();
    cycle();
    check("t4_regrant", last_req_ready, 4'b0010);
    req_valid = '0;

    // Flush in the 3rd WAIT cycle, then a normal request
    do_reset();
    stub_lat = 10;
    set_req(0, $urandom, $urandom);
    req_valid = 4'b0001;
    k = 0;
    while (!(op_live && op_issued && !have_resp && wait_cycles == 2) && k < 30) begin cycle(); k++; end
    c0 = n_cancel; rv0 = n_rv; r0 = n_resp;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (4) cycle();
    check("t5_cancel_count", n_cancel - c0, 1);
    check("t5_no_resp", n_rv - rv0, 0);
    set_req(1, $urandom, $urandom);
    req_valid = 4'b0010;
    run_until_resp(r0 + 1, 60);
    check("t5_after_id", log_id[log_id.size()-1], 1);

    // Flush coinciding with div_out_valid
    stub_lat = 2;
    set_req(0, $urandom, $urandom);
    req_valid = 4'b0001;
    k = 0;
    while (!(stub_busy && stub_cnt == 0 && op_issued && !have_resp) && k < 30) begin cycle(); k++; end
    rv0 = n_rv;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t5b_out_valid_seen", dif.div_out_valid, 1);
    repeat (4) cycle();
    check("t5b_no_resp", n_rv - rv0, 0);

    // Watchdog
    do_reset();
    hang_all = 1;
    set_req(3, $urandom, $urandom);
    req_valid = 4'b1000;
    c0 = n_cancel;
    run_until_resp(1, 60);
    check("t6_timeout_flag", log_to[0], 1);
    check("t6_data", log_data[0], 0);
    check("t6_exc", log_exc[0], 0);
    check("t6_latency", resp_start_cyc - hs_cyc, TO + 1);
    check("t6_cancel_count", n_cancel - c0, 1);

    // Reset asserted mid-operation
    do_reset();
    hang_all = 1;
    set_req(2, $urandom, $urandom);
    req_valid = 4'b0100;
    k = 0;
    while (!(op_live && op_issued && wait_cycles == 3) && k < 30) begin cycle(); k++; end
    req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    check("t7_req_ready", req_ready, 0);
    check("t7_div_in_valid", dif.div_in_valid, 0);
    check("t7_div_cancel", dif.div_cancel, 0);
    check("t7_div_a", dif.div_a, 0);
    check("t7_resp_valid", resp_valid, 0);
    check("t7_resp_id", resp_id, 0);
    check("t7_resp_timeout", resp_timeout, 0);
    do_reset();
    req_valid = 4'b1111;
    cycle();
    check("t7_first_grant", last_req_ready, 4'b0001);

    // Randomized traffic
    do_reset();
    spur_en = 1; rand_hang = 1; drop_on_grant = 0; ready_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < N; j++) begin
        req_valid[j] = $urandom_range(1);
        set_req(j, $urandom, $urandom);
      end
      round_mode = 3'($urandom);
      resp_ready = ($urandom_range(99) < 70);
      flush = ($urandom_range(99) < 3);
      stub_lat = $urandom_range(5);
      cycle();
    end
    flush = 1'b0;
    check("t8_some_responses", n_resp > 20, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one iterative floating-point divider among N_REQ requesters, e.g. the normalisation units of the neural-network layers. It accepts one operand pair at a time and issues it to the divider using the divider's valid/ready handshake. It returns the quotient and exception flags tagged with the requester ID. It also provides a flush path and a watchdog that cancel a hung operation.

## Interface

- N_REQ, 4, number of requesters (2..16)
- WIDTH, 32, operand width (exp_width + mant_width of the divider)
- ID_W, $clog2(N_REQ), requester-ID width
- TIMEOUT, 64, maximum WAIT-state cycles before the watchdog cancels the operation
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  N_REQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  divisors, same packing
- req_ready  out  N_REQ  one-hot accept strobe
- round_mode  in  3  rounding mode, sampled at grant
- flush  in  1  abort the in-flight operation
- div_in_valid  out  1  operand valid to the divider
- div_a, div_b  out  WIDTH  latched operands
- div_round_mode  out  3  latched rounding mode
- div_cancel  out  1  one-cycle cancel pulse to the divider
- div_in_ready  in  1  divider can accept operands
- div_out_valid  in  1  divider result valid (one-cycle pulse)
- div_out  in  WIDTH  divider quotient
- div_exceptions  in  5  divider exception flags
- resp_valid  out  1  response valid
- resp_data  out  WIDTH  quotient
- resp_exc  out  5  exception flags
- resp_id  out  ID_W  ID of the requester that issued the operation
- resp_timeout  out  1  response produced by the watchdog
- resp_ready  in  1  consumer accepts the response

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP. At most one operation is outstanding.
- **IDLE:**
  - If any req_valid is high, grant the first requester at or after (rr_ptr+1) mod N_REQ.
  - req_ready[g] is high combinationally in this cycle, and only for g.
  - On that clock edge: latch req_a[g], req_b[g], round_mode and g; set rr_ptr←g; go to ISSUE.
- **ISSUE:**
  - div_in_valid=1 with the latched operands.
  - Handshake completes on the edge where div_in_valid and div_in_ready are both high; then go to WAIT and clear wd_cnt.
- **WAIT:**
  - wd_cnt increments every cycle.
  - If div_out_valid: capture div_out/div_exceptions into resp_data/resp_exc, set resp_timeout=0, go to RESP.
  - Else if wd_cnt == TIMEOUT-1: pulse div_cancel, set resp_data=0, resp_exc=0, resp_timeout=1, go to RESP.
- **RESP:**
  - resp_valid=1; resp_data, resp_exc, resp_id and resp_timeout are held stable.
  - When resp_ready is high, go to IDLE.
- **flush:**
  - In ISSUE or WAIT: pulse div_cancel for one cycle, drop the operation with no response, go to IDLE.
  - In RESP: drop the pending response, go to IDLE.
  - In IDLE: ignored.
  - flush takes priority over div_out_valid, the watchdog and resp_ready in the same cycle.
- A requester whose req_valid is low when its turn comes is skipped. A lone requester is granted back-to-back.
- Operands are passed through bit-exact. No arithmetic is done in this block.

## Timing

- **Reset values:**
  - State IDLE; rr_ptr = N_REQ-1, so requester 0 has first priority.
  - All outputs 0; wd_cnt = 0.
- **Reset asserted mid-operation:** state returns to IDLE immediately (asynchronously). div_cancel is not pulsed, because the divider is reset with the same signal.
- **Grant to issue:** request accepted at edge T → div_in_valid high in cycle T+1.
- **Response:** div_out_valid in cycle D → resp_valid high from D+1.
- **Back-to-back:** after the resp_ready handshake at edge R, IDLE is in cycle R+1, so the next grant can happen in that cycle.
- **Throughput:** minimum one operation per divider latency + 3 cycles.
- **Unexpected result:** div_out_valid outside WAIT is ignored.
- **Watchdog:** a watchdog response appears exactly TIMEOUT cycles after entry to WAIT.

## Test plan

- **Single request:** requester 0 sends a=40C00000 (6.0), b=40000000 (2.0), round_mode=000 → one div_in_valid handshake; response resp_data=40400000, resp_exc=00000, resp_id=0, resp_timeout=0.
- **Simultaneous requests:** requester 2 sends C1400000/40800000 (-12/4) and requester 0 sends 40C00000/40000000 in the same cycle after reset → requester 0 served first (40400000), then requester 2 (C0400000, id=2).
- **Fairness:** all 4 requesters hold req_valid continuously for 8 operations → grant order 0,1,2,3,0,1,2,3; each req_ready is a single-cycle pulse.
- **Backpressure:** resp_ready held low for 5 cycles in RESP → resp_valid and resp_data stay stable, no req_ready pulses; state returns to IDLE the cycle after resp_ready rises.
- **Flush:** flush in the 3rd WAIT cycle → div_cancel high for exactly 1 cycle, no resp_valid, a later request completes normally. Also: flush together with div_out_valid in the same cycle → response dropped.
- **Watchdog:** divider stub never asserts div_out_valid, TIMEOUT=16 → after 16 WAIT cycles div_cancel pulses, then resp_valid with resp_timeout=1 and resp_data=0.
- **Reset mid-operation:** rst asserted during WAIT → all outputs 0 immediately; the first request after reset goes to requester 0.
